// File: rtl/ahblite_decode_mux_pkg.sv
// Shared AHB-Lite encodings for the decoder/mux and its default slave:
// transfer types, response codes and default-slave FSM states.
package ahblite_decode_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: two-cycle ERROR for active transfers to unmapped addresses,
// plus a fault address register and a saturating fault counter.
module ahblite_default_slave
  import ahblite_decode_mux_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hready,
  input  logic        dflt,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  output logic        ds_hready,
  output logic        ds_hresp,
  output logic [31:0] err_addr,
  output logic [7:0]  err_cnt
);

  ds_state_e state, state_nxt;
  logic      active;
  logic      fault;

  always_comb begin
    active = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      default:                   active = 1'b0;
    endcase
  end

  assign fault = hready && dflt && active;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= DS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = DS_IDLE;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    case (state)
      DS_IDLE: state_nxt = fault ? DS_ERR1 : DS_IDLE;
      DS_ERR1: begin
        state_nxt = DS_ERR2;
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
      end
      DS_ERR2: begin
        // a new unmapped transfer may be accepted on the closing ERR2 edge
        state_nxt = fault ? DS_ERR1 : DS_IDLE;
        ds_hresp  = HRESP_ERROR;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (fault) begin
      err_addr <= haddr;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ahblite_decode_mux.sv
// AHB-Lite address decoder and slave-response mux for NPORT base/mask ports,
// with a registered data-phase select and a built-in default slave.
module ahblite_decode_mux
  import ahblite_decode_mux_pkg::*;
#(
  parameter int                     NPORT     = 4,
  parameter logic [NPORT*32-1:0]    PORT_BASE = {32'h40000010, 32'h40000000, 32'h20000000, 32'h00000000},
  parameter logic [NPORT*32-1:0]    PORT_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000},
  parameter logic [NPORT-1:0]       PORT_EN   = 4'b1111
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  output logic [NPORT-1:0]    HSEL_O,
  input  logic [NPORT*32-1:0] HRDATA_S,
  input  logic [NPORT-1:0]    HREADYOUT_S,
  input  logic [NPORT-1:0]    HRESP_S,
  output logic [31:0]         HRDATA,
  output logic                HREADY,
  output logic                HRESP,
  output logic [31:0]         ERR_ADDR,
  output logic [7:0]          ERR_CNT
);

  logic [NPORT-1:0] match;
  logic             dflt;
  logic             hit;
  logic [NPORT:0]   sel_q;
  logic             ds_hready;
  logic             ds_hresp;

  for (genvar i = 0; i < NPORT; i++) begin : g_match
    assign match[i] = PORT_EN[i] &&
                      ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]);
  end

  // lowest index wins on overlapping windows
  always_comb begin
    HSEL_O = '0;
    hit    = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (match[i] && !hit) begin
        HSEL_O[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  assign dflt = ~|match;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= {dflt, HSEL_O};
  end

  // all-zero sel_q (only right after reset) reads as an idle OKAY bus
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (sel_q[NPORT]) begin
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end
    for (int i = 0; i < NPORT; i++) begin
      if (sel_q[i]) begin
        HRDATA = HRDATA_S[32*i +: 32];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

  ahblite_default_slave u_dflt (
    .hclk      (HCLK),
    .hresetn   (HRESETn),
    .hready    (HREADY),
    .dflt      (dflt),
    .htrans    (HTRANS),
    .haddr     (HADDR),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_addr  (ERR_ADDR),
    .err_cnt   (ERR_CNT)
  );

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Bench for ahblite_decode_mux: decode table, directed bus sequences and
// randomized traffic checked against a transaction-level bus model.
module tb_ahblite_decode_mux;

  localparam int NP = 4;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [NP*32-1:0] HRDATA_S;
  logic [NP-1:0]    HREADYOUT_S;
  logic [NP-1:0]    HRESP_S;

  logic [NP-1:0] hsel_a, hsel_b;
  logic [31:0]   hrdata_a, hrdata_b, err_addr_a, err_addr_b;
  logic          hready_a, hready_b, hresp_a, hresp_b;
  logic [7:0]    err_cnt_a, err_cnt_b;

  always #5 HCLK = ~HCLK;

  ahblite_decode_mux dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_O(hsel_a), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S(HRESP_S), .HRDATA(hrdata_a), .HREADY(hready_a), .HRESP(hresp_a),
    .ERR_ADDR(err_addr_a), .ERR_CNT(err_cnt_a)
  );

  // port 1 disabled, port 2 widened so it overlaps port 3
  ahblite_decode_mux #(
    .NPORT(4),
    .PORT_MASK({32'hFFFFFFF0, 32'hFFFFFF00, 32'hFFFF0000, 32'hFFFF0000}),
    .PORT_EN(4'b1101)
  ) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_O(hsel_b), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S(HRESP_S), .HRDATA(hrdata_b), .HREADY(hready_b), .HRESP(hresp_b),
    .ERR_ADDR(err_addr_b), .ERR_CNT(err_cnt_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Bus model for dut_a: who owns the data phase and how many error cycles remain
  logic [31:0] base_a [NP] = '{32'h00000000, 32'h20000000, 32'h40000000, 32'h40000010};
  logic [31:0] mask_a [NP] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFFFFF0};
  int          m_owner;   // -1 none, NP default slave, else port index
  int          m_err;     // error cycles still to present (2, 1, 0)
  logic [31:0] m_eaddr;
  int          m_cnt;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if ((a & mask_a[i]) == base_a[i]) return i;
    return NP;
  endfunction

  function automatic logic exp_ready();
    if (m_owner < 0)   return 1'b1;
    if (m_owner == NP) return m_err != 2;
    return HREADYOUT_S[m_owner];
  endfunction

  function automatic logic exp_resp();
    if (m_owner < 0)   return 1'b0;
    if (m_owner == NP) return m_err != 0;
    return HRESP_S[m_owner];
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_owner < 0 || m_owner == NP) return 32'h0;
    return HRDATA_S[32*m_owner +: 32];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_err = 0; m_eaddr = 32'h0; m_cnt = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Negedge sample of dut_a against the model
  task automatic at_neg();
    int d;
    @(negedge HCLK);
    d = decode(HADDR);
    check("hsel",     32'(hsel_a),    (d < NP) ? (32'h1 << d) : 32'h0);
    check("hrdata",   hrdata_a,       exp_rdata());
    check("hready",   32'(hready_a),  32'(exp_ready()));
    check("hresp",    32'(hresp_a),   32'(exp_resp()));
    check("err_addr", err_addr_a,     m_eaddr);
    check("err_cnt",  32'(err_cnt_a), 32'(m_cnt));
  endtask

  task automatic tick();
    logic r;
    int   d, nerr;
    @(posedge HCLK);
    r = exp_ready();
    d = decode(HADDR);
    nerr = (m_err == 2) ? 1 : 0;
    if (r && d == NP && HTRANS[1]) begin
      nerr    = 2;
      m_eaddr = HADDR;
      if (m_cnt < 255) m_cnt++;
    end
    if (r) m_owner = d;
    m_err = nerr;
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    at_neg();
    check("rst_hready", 32'(hready_a), 32'h1);
    check("rst_hresp",  32'(hresp_a),  32'h0);
    check("rst_hrdata", hrdata_a,      32'h0);
    check("rst_errcnt", 32'(err_cnt_a), 32'h0);
    check("rst_erradr", err_addr_a,    32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [1:0] t);
    HADDR = a; HTRANS = t;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  hsel_a;
    logic [3:0]  hsel_b;
  } dvec_t;

  dvec_t tbl [10];

  initial begin
    int c0;
    tbl[0] = '{32'h20000004, 4'b0010, 4'b0000};
    tbl[1] = '{32'h00001234, 4'b0001, 4'b0001};
    tbl[2] = '{32'h0000FFFF, 4'b0001, 4'b0001};
    tbl[3] = '{32'h00010000, 4'b0000, 4'b0000};
    tbl[4] = '{32'h40000004, 4'b0100, 4'b0100};
    tbl[5] = '{32'h4000001C, 4'b1000, 4'b0100};
    tbl[6] = '{32'h40000014, 4'b1000, 4'b0100};
    tbl[7] = '{32'h40000020, 4'b0000, 4'b0100};
    tbl[8] = '{32'h30000000, 4'b0000, 4'b0000};
    tbl[9] = '{32'h2000FFFC, 4'b0010, 4'b0000};

    HADDR = 32'h0; HTRANS = 2'b00; HRESP_S = '0; HREADYOUT_S = '1;
    for (int i = 0; i < NP; i++) HRDATA_S[32*i +: 32] = 32'hA5A50000 + 32'(i);
    do_reset();

    // decode table (IDLE/BUSY only, so no error waits)
    for (int i = 0; i < 10; i++) begin
      bus(tbl[i].addr, (i % 2) ? 2'b01 : 2'b00);
      at_neg();
      check("tbl_hsel_a", 32'(hsel_a), 32'(tbl[i].hsel_a));
      check("tbl_hsel_b", 32'(hsel_b), 32'(tbl[i].hsel_b));
      tick();
    end

    // zero-wait read from slave 1
    bus(32'h20000004, 2'b10); at_neg();
    check("rd1_hsel", 32'(hsel_a), 32'h2);
    tick();
    bus(32'h0, 2'b00); at_neg();
    check("rd1_data",  hrdata_a, 32'hA5A50001);
    check("rd1_ready", 32'(hready_a), 32'h1);
    check("rd1_resp",  32'(hresp_a),  32'h0);
    tick();

    // slave 3 inserts two wait states; next address held
    bus(32'h40000014, 2'b10); at_neg(); tick();
    HREADYOUT_S[3] = 1'b0; bus(32'h00000000, 2'b10);
    at_neg(); check("ws_ready0", 32'(hready_a), 32'h0);
    check("ws_hsel", 32'(hsel_a), 32'h1);
    tick();
    at_neg(); check("ws_ready1", 32'(hready_a), 32'h0); tick();
    HREADYOUT_S[3] = 1'b1;
    at_neg(); check("ws_release", 32'(hready_a), 32'h1); tick();
    bus(32'h0, 2'b00);
    at_neg(); check("ws_next_data", hrdata_a, 32'hA5A50000); tick();

    // single unmapped NONSEQ
    bus(32'h30000000, 2'b10); at_neg(); tick();
    bus(32'h0, 2'b00);
    at_neg(); check("e1_ready", 32'(hready_a), 32'h0); check("e1_resp", 32'(hresp_a), 32'h1); tick();
    at_neg(); check("e2_ready", 32'(hready_a), 32'h1); check("e2_resp", 32'(hresp_a), 32'h1); tick();
    at_neg(); check("e3_resp", 32'(hresp_a), 32'h0);
    check("e_addr", err_addr_a, 32'h30000000); check("e_cnt", 32'(err_cnt_a), 32'h1);
    tick();

    // back-to-back unmapped transfers
    do_reset();
    bus(32'h50000000, 2'b10); at_neg(); tick();
    bus(32'h50000004, 2'b10);
    at_neg(); check("bb_err1a", 32'({hready_a, hresp_a}), 32'h1); tick();
    at_neg(); check("bb_err2a", 32'({hready_a, hresp_a}), 32'h3); tick();
    bus(32'h0, 2'b00);
    at_neg(); check("bb_err1b", 32'({hready_a, hresp_a}), 32'h1); tick();
    at_neg(); check("bb_err2b", 32'({hready_a, hresp_a}), 32'h3); tick();
    at_neg(); check("bb_cnt", 32'(err_cnt_a), 32'h2); check("bb_addr", err_addr_a, 32'h50000004); tick();

    // IDLE to unmapped: OKAY, no count; then saturate the counter
    bus(32'h30000000, 2'b00); at_neg(); tick();
    at_neg(); check("idle_ready", 32'(hready_a), 32'h1); check("idle_resp", 32'(hresp_a), 32'h0);
    check("idle_cnt", 32'(err_cnt_a), 32'h2); tick();
    bus(32'h30000000, 2'b10);
    for (int i = 0; i < 600; i++) begin at_neg(); tick(); end
    bus(32'h0, 2'b00);
    at_neg(); tick();
    at_neg(); check("sat_cnt", 32'(err_cnt_a), 32'hFF); tick();

    // async reset during ERR1
    bus(32'h30000000, 2'b10); at_neg(); tick();
    bus(32'h0, 2'b00);
    at_neg(); check("ar_err1", 32'(hready_a), 32'h0);
    HRESETn = 1'b0; model_reset(); #1;
    check("ar_ready", 32'(hready_a), 32'h1);
    check("ar_resp",  32'(hresp_a),  32'h0);
    check("ar_cnt",   32'(err_cnt_a), 32'h0);
    @(posedge HCLK); #1 HRESETn = 1'b1;

    // disabled port on dut_b falls through to the default slave
    do_reset();
    bus(32'h20000000, 2'b10); at_neg();
    check("en_hsel_b", 32'(hsel_b), 32'h0); check("en_hsel_a", 32'(hsel_a), 32'h2); tick();
    bus(32'h0, 2'b00);
    at_neg(); check("en_err1", 32'({hready_b, hresp_b}), 32'h1); tick();
    at_neg(); check("en_err2", 32'({hready_b, hresp_b}), 32'h3);
    check("en_addr", err_addr_b, 32'h20000000); tick();
    at_neg(); check("en_done", 32'({hready_b, hresp_b}), 32'h2);
    check("en_cnt", 32'(err_cnt_b), 32'h1); tick();

    // randomized traffic against the model
    c0 = n_chk;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 6))
        0: HADDR = 32'h20000004;
        1: HADDR = 32'h00001234;
        2: HADDR = 32'h40000004;
        3: HADDR = 32'h40000018;
        4: HADDR = 32'h30000000 | 32'($urandom_range(0, 255));
        5: HADDR = 32'h50000004;
        default: HADDR = $urandom;
      endcase
      HTRANS = 2'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++) begin
        HREADYOUT_S[p] = ($urandom_range(0, 3) != 0);
        HRESP_S[p]     = ($urandom_range(0, 7) == 0);
        HRDATA_S[32*p +: 32] = $urandom;
      end
      at_neg();
      tick();
    end
    if (n_chk == c0) begin
      n_fail++;
      $display("FAIL rand_loop: got %0d checks expected more", n_chk - c0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
